// File: rtl/snax_alu_streamer_pkg.sv
// Shared types for the SNAX ALU streamer.
// Contents: streamer_state_e, the job-level FSM state encoding.
package snax_alu_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } streamer_state_e;

endpackage

// File: rtl/snax_alu_stream_fifo.sv
// Registered operand FIFO for one streamer input channel.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset (pointers/count only)
//   push_i, data_i       write side; push is dropped when full unless a pop happens too
//   pop_i, data_o        read side; data_o is the current head
//   empty_o, full_o      occupancy flags
//   count_o              number of stored entries
module snax_alu_stream_fifo #(
  parameter int unsigned Width = 256,
  parameter int unsigned Depth = 2,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [1 << PtrW];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok);

  // Storage carries data only and is left out of reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop_ok) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/snax_alu_streamer.sv
// Streamer for the SNAX ALU accelerator. Fetches operand beats A and B from
// two in-order read channels into small credit-limited FIFOs, presents them on
// stream2acc_0/1, and writes result beats from acc2stream_0 to memory at base_c.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   start_i, base_[abc]_i, len_i      job launch (len_i = 0 completes immediately)
//   busy_o, done_o                    RUN indicator, one-cycle completion pulse
//   perf_cycles_o                     RUN cycle counter (zero unless enabled)
//   rd_[ab]_req_*, rd_[ab]_rsp_*      operand read request/response channels
//   wr_c_req_*                        result write channel
//   stream2acc_[01]_*, acc2stream_0_* accelerator valid/ready streams
// Build option: define SNAX_ALU_STREAMER_PERF_EN to synthesize the cycle counter.
module snax_alu_streamer
  import snax_alu_streamer_pkg::*;
#(
  parameter int unsigned NumPE      = 4,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned CountWidth = 16,
  parameter int unsigned FifoDepth  = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [AddrWidth-1:0]           base_a_i,
  input  logic [AddrWidth-1:0]           base_b_i,
  input  logic [AddrWidth-1:0]           base_c_i,
  input  logic [CountWidth-1:0]          len_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [31:0]                    perf_cycles_o,
  output logic                           rd_a_req_valid_o,
  input  logic                           rd_a_req_ready_i,
  output logic [AddrWidth-1:0]           rd_a_req_addr_o,
  input  logic                           rd_a_rsp_valid_i,
  input  logic [NumPE*DataWidth-1:0]     rd_a_rsp_data_i,
  output logic                           rd_b_req_valid_o,
  input  logic                           rd_b_req_ready_i,
  output logic [AddrWidth-1:0]           rd_b_req_addr_o,
  input  logic                           rd_b_rsp_valid_i,
  input  logic [NumPE*DataWidth-1:0]     rd_b_rsp_data_i,
  output logic                           wr_c_req_valid_o,
  input  logic                           wr_c_req_ready_i,
  output logic [AddrWidth-1:0]           wr_c_req_addr_o,
  output logic [NumPE*DataWidth*2-1:0]   wr_c_req_data_o,
  output logic [NumPE*DataWidth-1:0]     stream2acc_0_data_o,
  output logic                           stream2acc_0_valid_o,
  input  logic                           stream2acc_0_ready_i,
  output logic [NumPE*DataWidth-1:0]     stream2acc_1_data_o,
  output logic                           stream2acc_1_valid_o,
  input  logic                           stream2acc_1_ready_i,
  input  logic [NumPE*DataWidth*2-1:0]   acc2stream_0_data_i,
  input  logic                           acc2stream_0_valid_i,
  output logic                           acc2stream_0_ready_o
);

  localparam int unsigned LaneW        = NumPE * DataWidth;
  localparam int unsigned BeatBytesIn  = LaneW / 8;
  localparam int unsigned BeatBytesOut = 2 * BeatBytesIn;
  localparam int unsigned CntW         = $clog2(FifoDepth + 1);

  streamer_state_e       state_q, state_d;
  logic [CountWidth-1:0] len_q, wr_cnt_q;
  logic [AddrWidth-1:0]  base_c_q;
  logic                  run, start_idle, job_start, wr_qual, wr_fire;

  assign run        = (state_q == ST_RUN);
  assign start_idle = start_i && (state_q == ST_IDLE);
  assign job_start  = start_idle && (len_i != '0);

  // Channel 0 = A, channel 1 = B.
  logic [1:0]           req_valid, req_ready, rsp_valid, s_valid, s_ready;
  logic [AddrWidth-1:0] base_in  [2];
  logic [AddrWidth-1:0] req_addr [2];
  logic [LaneW-1:0]     rsp_data [2];
  logic [LaneW-1:0]     s_data   [2];

  assign base_in[0]  = base_a_i;
  assign base_in[1]  = base_b_i;
  assign rsp_data[0] = rd_a_rsp_data_i;
  assign rsp_data[1] = rd_b_rsp_data_i;
  assign req_ready   = {rd_b_req_ready_i, rd_a_req_ready_i};
  assign rsp_valid   = {rd_b_rsp_valid_i, rd_a_rsp_valid_i};
  assign s_ready     = {stream2acc_1_ready_i, stream2acc_0_ready_i};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [AddrWidth-1:0]  base_q;
    logic [CountWidth-1:0] req_cnt_q;
    logic [CntW-1:0]       outst_q, fifo_cnt;
    logic [CntW:0]         credit_used;
    logic                  fifo_empty, fifo_full, req_fire, push, pop;

    // Outstanding requests reserve FIFO slots, so responses can never overflow.
    assign credit_used  = {1'b0, outst_q} + {1'b0, fifo_cnt};
    assign req_valid[c] = run && (req_cnt_q < len_q) &&
                          (credit_used < (CntW + 1)'(FifoDepth));
    assign req_addr[c]  = base_q + AddrWidth'(req_cnt_q) * AddrWidth'(BeatBytesIn);
    assign req_fire     = req_valid[c] && req_ready[c];
    assign pop          = s_valid[c] && s_ready[c];
    // Late responses from an aborted job land in IDLE and are discarded.
    assign push         = rsp_valid[c] && (state_q != ST_IDLE) && (!fifo_full || pop);
    assign s_valid[c]   = !fifo_empty;

    snax_alu_stream_fifo #(
      .Width (LaneW),
      .Depth (FifoDepth)
    ) i_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (rsp_data[c]),
      .pop_i   (pop),
      .data_o  (s_data[c]),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (fifo_cnt)
    );

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        base_q    <= '0;
        req_cnt_q <= '0;
        outst_q   <= '0;
      end else if (job_start) begin
        base_q    <= base_in[c];
        req_cnt_q <= '0;
        outst_q   <= '0;
      end else begin
        if (req_fire) req_cnt_q <= req_cnt_q + 1'b1;
        if (req_fire && !push)      outst_q <= outst_q + 1'b1;
        else if (!req_fire && push) outst_q <= outst_q - 1'b1;
      end
    end
  end

  assign rd_a_req_valid_o     = req_valid[0];
  assign rd_a_req_addr_o      = req_addr[0];
  assign rd_b_req_valid_o     = req_valid[1];
  assign rd_b_req_addr_o      = req_addr[1];
  assign stream2acc_0_valid_o = s_valid[0];
  assign stream2acc_0_data_o  = s_data[0];
  assign stream2acc_1_valid_o = s_valid[1];
  assign stream2acc_1_data_o  = s_data[1];

  // Result path is purely combinational from the accelerator to memory.
  assign wr_qual              = run && (wr_cnt_q < len_q);
  assign wr_c_req_valid_o     = acc2stream_0_valid_i && wr_qual;
  assign acc2stream_0_ready_o = wr_c_req_ready_i && wr_qual;
  assign wr_fire              = acc2stream_0_valid_i && wr_c_req_ready_i && wr_qual;
  assign wr_c_req_addr_o      = base_c_q + AddrWidth'(wr_cnt_q) * AddrWidth'(BeatBytesOut);
  assign wr_c_req_data_o      = acc2stream_0_data_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = (len_i == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (wr_fire && (wr_cnt_q == len_q - 1'b1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      base_c_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (job_start) begin
        len_q    <= len_i;
        base_c_q <= base_c_i;
        wr_cnt_q <= '0;
      end else if (wr_fire) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
      end
    end
  end

  assign busy_o = run;
  assign done_o = (state_q == ST_DONE);

`ifdef SNAX_ALU_STREAMER_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)           perf_q <= '0;
    else if (start_idle) perf_q <= '0;
    else if (run)        perf_q <= perf_q + 1'b1;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_snax_alu_streamer.sv
module tb_snax_alu_streamer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [31:0]  base_a_i, base_b_i, base_c_i;
  logic [15:0]  len_i;
  logic         busy_o, done_o;
  logic [31:0]  perf_cycles_o;
  logic         rd_a_req_valid_o, rd_a_req_ready_i, rd_a_rsp_valid_i;
  logic [31:0]  rd_a_req_addr_o;
  logic [255:0] rd_a_rsp_data_i;
  logic         rd_b_req_valid_o, rd_b_req_ready_i, rd_b_rsp_valid_i;
  logic [31:0]  rd_b_req_addr_o;
  logic [255:0] rd_b_rsp_data_i;
  logic         wr_c_req_valid_o, wr_c_req_ready_i;
  logic [31:0]  wr_c_req_addr_o;
  logic [511:0] wr_c_req_data_o;
  logic [255:0] stream2acc_0_data_o, stream2acc_1_data_o;
  logic         stream2acc_0_valid_o, stream2acc_0_ready_i;
  logic         stream2acc_1_valid_o, stream2acc_1_ready_i;
  logic [511:0] acc2stream_0_data_i;
  logic         acc2stream_0_valid_i, acc2stream_0_ready_o;

  snax_alu_streamer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .base_a_i(base_a_i), .base_b_i(base_b_i), .base_c_i(base_c_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .perf_cycles_o(perf_cycles_o),
    .rd_a_req_valid_o(rd_a_req_valid_o), .rd_a_req_ready_i(rd_a_req_ready_i),
    .rd_a_req_addr_o(rd_a_req_addr_o), .rd_a_rsp_valid_i(rd_a_rsp_valid_i),
    .rd_a_rsp_data_i(rd_a_rsp_data_i),
    .rd_b_req_valid_o(rd_b_req_valid_o), .rd_b_req_ready_i(rd_b_req_ready_i),
    .rd_b_req_addr_o(rd_b_req_addr_o), .rd_b_rsp_valid_i(rd_b_rsp_valid_i),
    .rd_b_rsp_data_i(rd_b_rsp_data_i),
    .wr_c_req_valid_o(wr_c_req_valid_o), .wr_c_req_ready_i(wr_c_req_ready_i),
    .wr_c_req_addr_o(wr_c_req_addr_o), .wr_c_req_data_o(wr_c_req_data_o),
    .stream2acc_0_data_o(stream2acc_0_data_o), .stream2acc_0_valid_o(stream2acc_0_valid_o),
    .stream2acc_0_ready_i(stream2acc_0_ready_i),
    .stream2acc_1_data_o(stream2acc_1_data_o), .stream2acc_1_valid_o(stream2acc_1_valid_o),
    .stream2acc_1_ready_i(stream2acc_1_ready_i),
    .acc2stream_0_data_i(acc2stream_0_data_i), .acc2stream_0_valid_i(acc2stream_0_valid_i),
    .acc2stream_0_ready_o(acc2stream_0_ready_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Scoreboard queues filled by the stimulus.
  logic [31:0]  exp_ra[$], exp_rb[$], exp_wa[$];
  logic [511:0] exp_wd[$];

  // Memory and accelerator model state.
  logic         pend_a = 1'b0, pend_b = 1'b0;
  logic [31:0]  pend_a_addr = '0, pend_b_addr = '0;
  logic [255:0] opa_q[$], opb_q[$];
  logic [511:0] res_q[$];
  int           s0_stall = 0;
  int           wr_stall_left = 0;
  bit           wr_stall_arm = 0;

  // Monitor statistics.
  int           req_seen = 0, wr_done_cnt = 0, done_cnt = 0, last_wr_cyc = 0;
  int           occ_a = 0, max_occ_a = 0;
  bit           have_held = 0;
  logic [31:0]  held_addr = '0;

  function automatic logic [255:0] memdata(input logic [31:0] a);
    return {4{a, ~a}};
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory (1-cycle response latency) and accelerator (C = {A, B}) models.
  initial begin
    forever begin
      @(negedge clk_i);
      rd_a_rsp_valid_i     = pend_a;
      rd_a_rsp_data_i      = memdata(pend_a_addr);
      rd_b_rsp_valid_i     = pend_b;
      rd_b_rsp_data_i      = memdata(pend_b_addr);
      rd_a_req_ready_i     = 1'b1;
      rd_b_req_ready_i     = 1'b1;
      stream2acc_0_ready_i = (s0_stall == 0);
      if (s0_stall > 0) s0_stall--;
      stream2acc_1_ready_i = 1'b1;
      wr_c_req_ready_i     = (wr_stall_left == 0);
      if (wr_stall_left > 0) wr_stall_left--;
      acc2stream_0_valid_i = (res_q.size() > 0);
      acc2stream_0_data_i  = (res_q.size() > 0) ? res_q[0] : '0;
      #1;
      pend_a      = rd_a_req_valid_o && rd_a_req_ready_i;
      pend_a_addr = rd_a_req_addr_o;
      pend_b      = rd_b_req_valid_o && rd_b_req_ready_i;
      pend_b_addr = rd_b_req_addr_o;
      if (stream2acc_0_valid_o && stream2acc_0_ready_i) opa_q.push_back(stream2acc_0_data_o);
      if (stream2acc_1_valid_o && stream2acc_1_ready_i) opb_q.push_back(stream2acc_1_data_o);
      while (opa_q.size() > 0 && opb_q.size() > 0)
        res_q.push_back({opa_q.pop_front(), opb_q.pop_front()});
      if (wr_c_req_valid_o && wr_c_req_ready_i) begin
        void'(res_q.pop_front());
        if (wr_stall_arm) begin
          wr_stall_arm  = 0;
          wr_stall_left = 5;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT completes a handshake.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (rd_a_req_valid_o || rd_b_req_valid_o) req_seen++;
      if (done_o) done_cnt++;
      if (rd_a_req_valid_o && rd_a_req_ready_i) begin
        if (exp_ra.size() == 0) begin
          total++; bad++;
          $display("FAIL ra_extra: got addr %0h expected no request", rd_a_req_addr_o);
        end else check("ra_addr", rd_a_req_addr_o, exp_ra.pop_front());
        occ_a++;
      end
      if (stream2acc_0_valid_o && stream2acc_0_ready_i) occ_a--;
      if (occ_a > max_occ_a) max_occ_a = occ_a;
      if (rd_b_req_valid_o && rd_b_req_ready_i) begin
        if (exp_rb.size() == 0) begin
          total++; bad++;
          $display("FAIL rb_extra: got addr %0h expected no request", rd_b_req_addr_o);
        end else check("rb_addr", rd_b_req_addr_o, exp_rb.pop_front());
      end
      if (wr_c_req_valid_o && wr_c_req_ready_i) begin
        if (exp_wa.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_extra: got addr %0h expected no write", wr_c_req_addr_o);
        end else begin
          check("wr_addr", wr_c_req_addr_o, exp_wa.pop_front());
          check("wr_data", wr_c_req_data_o, exp_wd.pop_front());
        end
        wr_done_cnt++;
        last_wr_cyc = cyc;
      end
      if (busy_o && !wr_c_req_ready_i) begin
        check("stall_acc_ready", acc2stream_0_ready_o, 0);
        if (wr_c_req_valid_o) begin
          if (have_held) check("stall_addr_stable", wr_c_req_addr_o, held_addr);
          held_addr = wr_c_req_addr_o;
          have_held = 1;
        end
      end else have_held = 0;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_perf"}, perf_cycles_o, 0);
    check({tag, "_ra_valid"}, rd_a_req_valid_o, 0);
    check({tag, "_rb_valid"}, rd_b_req_valid_o, 0);
    check({tag, "_ra_addr"}, rd_a_req_addr_o, 0);
    check({tag, "_rb_addr"}, rd_b_req_addr_o, 0);
    check({tag, "_wr_valid"}, wr_c_req_valid_o, 0);
    check({tag, "_wr_addr"}, wr_c_req_addr_o, 0);
    check({tag, "_s0_valid"}, stream2acc_0_valid_o, 0);
    check({tag, "_s1_valid"}, stream2acc_1_valid_o, 0);
    check({tag, "_acc_ready"}, acc2stream_0_ready_o, 0);
  endtask

  task automatic push_expect(input logic [31:0] ba, input logic [31:0] bb,
                             input logic [31:0] bc, input int len);
    for (int i = 0; i < len; i++) begin
      exp_ra.push_back(ba + 32'(i) * 32'h20);
      exp_rb.push_back(bb + 32'(i) * 32'h20);
      exp_wa.push_back(bc + 32'(i) * 32'h40);
      exp_wd.push_back({memdata(ba + 32'(i) * 32'h20), memdata(bb + 32'(i) * 32'h20)});
    end
  endtask

  task automatic run_job(input string tag, input logic [31:0] ba, input logic [31:0] bb,
                         input logic [31:0] bc, input int len);
    int n;
    int start_cyc;
    int exp_perf;
    push_expect(ba, bb, bc, len);
    done_cnt    = 0;
    wr_done_cnt = 0;
    @(negedge clk_i);
    base_a_i = ba; base_b_i = bb; base_c_i = bc; len_i = 16'(len);
    start_i  = 1'b1;
    start_cyc = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
    if (len == 0) begin
      check({tag, "_len0_done_next"}, done_o, 1);
    end else begin
      check({tag, "_busy_after_start"}, busy_o, 1);
      check({tag, "_first_req"}, rd_a_req_valid_o, 1);
    end
    n = 0;
    while (!done_o && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    if (!done_o) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", tag, n);
    end else begin
      if (len > 0) check({tag, "_done_timing"}, cyc, last_wr_cyc + 1);
      exp_perf = (len == 0) ? 0 : last_wr_cyc - start_cyc;
`ifdef SNAX_ALU_STREAMER_PERF_EN
      check({tag, "_perf"}, perf_cycles_o, exp_perf);
`else
      check({tag, "_perf_off"}, perf_cycles_o, 0);
      if (exp_perf < 0) $display("note: unexpected write timing in %s", tag);
`endif
    end
    @(negedge clk_i);
    #3;
    check({tag, "_done_pulse_end"}, done_o, 0);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_write_count"}, wr_done_cnt, len);
    check({tag, "_exp_left"}, exp_wa.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i = 1'b1; start_i = 1'b0;
    base_a_i = '0; base_b_i = '0; base_c_i = '0; len_i = '0;
    rd_a_req_ready_i = 1'b1; rd_b_req_ready_i = 1'b1;
    rd_a_rsp_valid_i = 1'b0; rd_b_rsp_valid_i = 1'b0;
    rd_a_rsp_data_i = '0; rd_b_rsp_data_i = '0;
    wr_c_req_ready_i = 1'b1; stream2acc_0_ready_i = 1'b1; stream2acc_1_ready_i = 1'b1;
    acc2stream_0_valid_i = 1'b0; acc2stream_0_data_i = '0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Basic job with always-ready accelerator.
    run_job("basic", 32'h1000, 32'h2000, 32'h3000, 4);

    // Empty job: immediate done, no traffic.
    req_seen = 0;
    run_job("len0", 32'h4000, 32'h5000, 32'h6000, 0);
    repeat (3) @(negedge clk_i);
    check("len0_no_req", req_seen, 0);

    // Operand A backpressure: occupancy must respect FIFO depth.
    occ_a = 0; max_occ_a = 0;
    s0_stall = 10;
    run_job("bp_a", 32'h0100, 32'h0200, 32'h0300, 6);
    total++;
    if (max_occ_a > 2) begin
      bad++;
      $display("FAIL bp_a_occupancy: got %0d expected at most 2", max_occ_a);
    end

    // Write backpressure for 5 cycles after the first write.
    wr_stall_arm = 1;
    run_job("bp_wr", 32'h7000, 32'h8000, 32'h9000, 5);

    // Reset in the middle of a len=8 job.
    push_expect(32'h1_0000, 32'h2_0000, 32'h3_0000, 8);
    wr_done_cnt = 0;
    @(negedge clk_i);
    base_a_i = 32'h1_0000; base_b_i = 32'h2_0000; base_c_i = 32'h3_0000; len_i = 16'd8;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 0;
    while (wr_done_cnt < 2 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (wr_done_cnt < 2) begin
      total++; bad++;
      $display("FAIL abort_wait: got %0d writes expected 2", wr_done_cnt);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("abort");
    rst_i = 1'b0;
    #3;
    exp_ra.delete(); exp_rb.delete(); exp_wa.delete(); exp_wd.delete();
    opa_q.delete(); opb_q.delete(); res_q.delete();
    repeat (2) @(negedge clk_i);
    run_job("after_abort", 32'h0A00, 32'h0B00, 32'h0C00, 2);

    // Full-throughput job used for the RUN-cycle counter.
    run_job("perf", 32'hA000, 32'hB000, 32'hC000, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
